// File: rtl/prog_loader_if.sv
// Byte-stream handshake from the frame source into the loader; a byte moves when valid and ready are both high.
interface prog_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data_i;
  logic              in_valid_i;
  logic              in_ready_o;

  modport master (output in_data_i, output in_valid_i, input in_ready_o);
  modport slave  (input in_data_i, input in_valid_i, output in_ready_o);
endinterface

// File: rtl/prog_loader.sv
// Loads one program frame (header N, operand, N words) into a small store, then runs the core and watches halt/run length.
// Stream is back-pressured only while the core runs; core reset releases one cycle after the last word is accepted.
module prog_loader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int RUN_MAX = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  prog_loader_if.slave      in_if,
  input  logic [ADDR_W-1:0] prog_addr_i,
  output logic [DATA_W-1:0] prog_data_o,
  output logic [DATA_W-1:0] operand_o,
  output logic              core_rst_no,
  input  logic              halt_i,
  output logic              busy_o,
  output logic              load_err_o,
  output logic              timeout_o,
  output logic [15:0]       cycles_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {S_HDR, S_OPR, S_PROG, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_store [DEPTH];
  logic [DATA_W-1:0]   r_operand;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W:0]     r_nwords;
  logic                r_core_rst_n;
  logic                r_load_err;
  logic                r_timeout;
  logic [15:0]         r_cycles;

  logic                w_ready;
  logic                w_busy;
  logic                w_accept;
  logic                w_hdr_ok;
  logic                w_last;
  logic                w_run_limit;

  assign w_accept    = in_if.in_valid_i & w_ready;
  assign w_hdr_ok    = (in_if.in_data_i != '0) &&
                       ({1'b0, in_if.in_data_i} <= (DATA_W + 1)'(DEPTH));
  assign w_last      = ({1'b0, r_cnt} == (r_nwords - 1'b1));
  assign w_run_limit = (r_cycles == 16'(RUN_MAX));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_HDR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR, S_DONE: if (w_accept) w_state_nxt = w_hdr_ok ? S_OPR : S_HDR;
      S_OPR:         if (w_accept) w_state_nxt = S_PROG;
      S_PROG:        if (w_accept && w_last) w_state_nxt = S_RUN;
      // halt takes priority over the run-length limit
      S_RUN: begin
        if (halt_i)           w_state_nxt = S_DONE;
        else if (w_run_limit) w_state_nxt = S_HDR;
      end
      default:       w_state_nxt = S_HDR;
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b0;
    case (r_state)
      S_OPR, S_PROG: w_busy = 1'b1;
      S_RUN: begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_store[i] <= '0;
      r_operand    <= '0;
      r_cnt        <= '0;
      r_nwords     <= '0;
      r_core_rst_n <= 1'b0;
      r_load_err   <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycles     <= '0;
    end else begin
      case (r_state)
        S_HDR, S_DONE: begin
          if (w_accept) begin
            r_core_rst_n <= 1'b0;
            if (w_hdr_ok) begin
              for (int i = 0; i < DEPTH; i++) r_store[i] <= '0;
              r_cnt      <= '0;
              r_nwords   <= in_if.in_data_i[ADDR_W:0];
              r_load_err <= 1'b0;
              r_timeout  <= 1'b0;
              r_cycles   <= '0;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        S_OPR: if (w_accept) r_operand <= in_if.in_data_i;
        S_PROG: begin
          if (w_accept) begin
            r_store[r_cnt] <= in_if.in_data_i;
            r_cnt          <= r_cnt + 1'b1;
            if (w_last) r_core_rst_n <= 1'b1;
          end
        end
        S_RUN: begin
          if (!halt_i) begin
            if (w_run_limit) begin
              r_timeout    <= 1'b1;
              r_core_rst_n <= 1'b0;
            end else if (r_cycles != 16'hFFFF) begin
              r_cycles <= r_cycles + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_if.in_ready_o = w_ready;
  assign busy_o           = w_busy;
  assign prog_data_o      = r_store[prog_addr_i];
  assign operand_o        = r_operand;
  assign core_rst_no      = r_core_rst_n;
  assign load_err_o       = r_load_err;
  assign timeout_o        = r_timeout;
  assign cycles_o         = r_cycles;
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the core.
- Accepts a byte stream carrying one program frame: header, operand, then N program words.
- Fills a small program store that the core reads through its program address bus, and drives the core operand input.
- Holds the core in reset during loading, releases it when the load completes, and watches core halt and run length.

Parameters:
DATA_W, 8, program word and stream byte width
ADDR_W, 2, program address width; DEPTH = 2**ADDR_W words
RUN_MAX, 1024, run-cycle limit before timeout (must be < 2**16)

Ports:
clk_i  in  1  system clock, all logic rising-edge
rst_i  in  1  asynchronous active-high reset
in_data_i  in  DATA_W  frame byte stream
in_valid_i  in  1  stream byte valid
in_ready_o  out  1  loader ready; byte accepted when in_valid_i & in_ready_o
prog_addr_i  in  ADDR_W  core program address
prog_data_o  out  DATA_W  program word at prog_addr_i (combinational read)
operand_o  out  DATA_W  registered operand; drives core ext_data_i
core_rst_no  out  1  core active-low reset; drives core n_rst_i
halt_i  in  1  core halt, sampled on clk_i
busy_o  out  1  high while loading or running
load_err_o  out  1  sticky: bad header seen
timeout_o  out  1  sticky: run exceeded RUN_MAX cycles
cycles_o  out  16  cycles spent in RUN for the current/last program

Behaviour:
- Reset (async assert, sync to clk_i on release):
  - state=HDR; store all zero; operand_o=0; core_rst_no=0; in_ready_o=1; busy_o=0; load_err_o=0; timeout_o=0; cycles_o=0.
- States: HDR, OPR, PROG, RUN, DONE. in_ready_o=1 in HDR, OPR, PROG and DONE; 0 in RUN.
- Header byte (accepted in HDR or DONE):
  - N = in_data_i. Valid iff 1 <= N <= DEPTH.
  - Valid header: all store words cleared to 0; word counter=0; load_err_o cleared; timeout_o cleared; cycles_o cleared; core_rst_no=0 from the next cycle; go to OPR.
  - Invalid header: byte dropped; load_err_o set; state goes to/stays in HDR; core_rst_no forced 0.
- OPR: accepted byte is registered into operand_o; go to PROG.
- PROG:
  - Each accepted byte is written to store[counter]; counter increments.
  - On accepting the Nth byte, go to RUN.
  - core_rst_no goes 1 on the cycle after the last byte is accepted (registered; 1-cycle latency).
- RUN:
  - core_rst_no=1; cycles_o increments each cycle, saturating at 16'hFFFF.
  - halt_i=1 -> DONE, cycles_o frozen.
  - If cycles_o reaches RUN_MAX with no halt: timeout_o set; core_rst_no=0; go to HDR.
  - Halt and timeout in the same cycle: halt wins.
- DONE:
  - core_rst_no stays 1 so core outputs remain observable; cycles_o held.
  - Only a header byte is meaningful; it starts a new load as above.
- halt_i is ignored outside RUN.
- busy_o=1 in OPR, PROG, RUN; 0 in HDR, DONE.
- prog_data_o = store[prog_addr_i] at all times, including during load.
- operand_o is stable from the OPR accept until the next OPR accept.
- in_valid_i low mid-frame: state and counter hold indefinitely; no timeout during load.
- rst_i mid-load or mid-run: immediate return to reset values; the partial frame is discarded.

Test Plan:
- Reset, then frame 02,04,A1,B2 (valid each cycle) -> operand_o=04; store=A1,B2,00,00; core_rst_no rises exactly 1 cycle after B2 accept; busy_o=1 until halt.
- In RUN, assert halt_i after 7 cycles -> state DONE; cycles_o=7; in_ready_o=1; core_rst_no stays 1; prog_data_o at addr 1 = B2.
- From DONE, send header 05 (> DEPTH) -> load_err_o=1, byte dropped, core_rst_no=0. Then 01,02,C3 -> load_err_o clears on the 01 accept; operand_o=02; store[0]=C3, others 0.
- Frame 04,09,11,22,33,44 with in_valid_i toggling every cycle -> same final store 11,22,33,44 as the back-to-back case; no bytes dropped; in_ready_o=0 during RUN.
- RUN_MAX=16, no halt -> timeout_o=1 when cycles_o=16; core_rst_no=0; state HDR. Halt_i and limit in the same cycle -> DONE, timeout_o=0.
- Assert rst_i during PROG after 1 of 3 words -> all outputs at reset values immediately; store all zero.
